ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 62 ++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: two-entry skid buffer between ALU and memory stages with branch resolution at accept.
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic        in_zero,
    input  logic        in_ltz,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic [1:0]  in_br_type,
    input  logic [31:0] in_br_target,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        br_taken,
    output logic [31:0] br_target
);
    logic [37:0] main_q, skid_q, in_entry;
    logic        main_valid, skid_valid, accept, pop, taken;
    always_comb begin
        in_entry = {in_result, in_rd, in_reg_write};
        accept   = in_valid && in_ready && !flush;
        pop      = main_valid && out_ready;
        taken    = in_br_type == 2'b01 ? in_zero :
                   in_br_type == 2'b10 ? !in_zero :
                   in_br_type == 2'b11 ? in_ltz : 1'b0;
    end
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign {out_result, out_rd, out_reg_write} = main_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            br_taken   <= 1'b0;
            br_target  <= '0;
        end else begin
            br_taken <= accept && taken;
            if (accept && taken) br_target <= in_br_target;
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (pop || !main_valid) begin
                // skid is only ever full while main is full, so it always drains first
                main_valid <= skid_valid || accept;
                if (skid_valid) main_q <= skid_q;
                else if (accept) main_q <= in_entry;
                skid_valid <= 1'b0;
            end else if (accept) begin
                skid_q     <= in_entry;
                skid_valid <= 1'b1;
            end
        end
    end
endmodule
